// File: rtl/sbox_chk_pkg.sv
// Shared constants and FSM encoding for the S-box sweep checker.
package sbox_chk_pkg;
    localparam int          N        = 6;
    localparam int          SIZE     = 64;
    localparam logic [11:0] PERM_SUM = 12'd2016;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;
endpackage

// File: rtl/sbox_seen_bitmap.sv
// One bit per possible S-box output; hit reports whether addr was already set.
module sbox_seen_bitmap #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         set,
    input  logic [N-1:0] addr,
    output logic         hit
);
    logic [2**N-1:0] bits_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            bits_q <= '0;
        end else if (set) begin
            bits_q[addr] <= 1'b1;
        end
    end

    assign hit = bits_q[addr];
endmodule

// File: rtl/sbox_sweep_checker.sv
// Sweeps x = 0..2^N-1 through an external S-box, stores the responses and
// reports bijectivity, first duplicate, fixed-point count and a sum checksum.
module sbox_sweep_checker #(
    parameter int N   = 6,
    parameter int LAT = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   sbox_x,
    input  logic [N-1:0]   sbox_y,
    output logic           bijective,
    output logic           dup_found,
    output logic [N-1:0]   first_dup_x,
    output logic [N:0]     fixed_cnt,
    output logic [2*N-1:0] y_sum,
    input  logic [N-1:0]   rd_addr,
    output logic [N-1:0]   rd_data
);
    import sbox_chk_pkg::*;

    localparam int         DEPTH = 2**N;
    localparam logic [2:0] LAT_C = 3'(LAT);

    state_e state_q, state_d;

    logic [N-1:0]   x_q, x_d;
    logic [2:0]     sub_q, sub_d;
    logic           dup_q, dup_d;
    logic [N-1:0]   fdx_q, fdx_d;
    logic [N:0]     fix_q, fix_d;
    logic [2*N-1:0] sum_q, sum_d;
    logic           bij_q, bij_d;
    logic [N-1:0]   tbl_q [DEPTH];

    logic accept, sample, last, clr, hit;

    assign accept = (state_q == IDLE) && start;
    assign sample = (state_q == SWEEP) && (sub_q == LAT_C);
    assign last   = sample && (x_q == N'(DEPTH - 1));

    sbox_seen_bitmap #(.N(N)) u_seen (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .set  (sample),
        .addr (sbox_y),
        .hit  (hit)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SWEEP;
            SWEEP:   if (last)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            SWEEP:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next state; bijective must see a duplicate found on the final sample.
    always_comb begin
        x_d   = x_q;
        sub_d = sub_q;
        dup_d = dup_q;
        fdx_d = fdx_q;
        fix_d = fix_q;
        sum_d = sum_q;
        bij_d = bij_q;
        clr   = 1'b0;
        if (accept) begin
            x_d   = '0;
            sub_d = '0;
            dup_d = 1'b0;
            fdx_d = '0;
            fix_d = '0;
            sum_d = '0;
            bij_d = 1'b0;
            clr   = 1'b1;
        end else if (sample) begin
            sub_d = '0;
            x_d   = x_q + 1'b1;
            if (hit && !dup_q) begin
                dup_d = 1'b1;
                fdx_d = x_q;
            end
            if (sbox_y == x_q) fix_d = fix_q + 1'b1;
            sum_d = sum_q + {{N{1'b0}}, sbox_y};
            if (last) bij_d = ~dup_d;
        end else if (state_q == SWEEP) begin
            sub_d = sub_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q   <= '0;
            sub_q <= '0;
            dup_q <= 1'b0;
            fdx_q <= '0;
            fix_q <= '0;
            sum_q <= '0;
            bij_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            sub_q <= sub_d;
            dup_q <= dup_d;
            fdx_q <= fdx_d;
            fix_q <= fix_d;
            sum_q <= sum_d;
            bij_q <= bij_d;
        end
    end

    // Table contents are don't-care after reset, so no reset branch.
    always_ff @(posedge clk) begin
        if (sample) tbl_q[x_q] <= sbox_y;
    end

    assign sbox_x      = x_q;
    assign bijective   = bij_q;
    assign dup_found   = dup_q;
    assign first_dup_x = fdx_q;
    assign fixed_cnt   = fix_q;
    assign y_sum       = sum_q;
    assign rd_data     = tbl_q[rd_addr];
endmodule

// File: tb/tb_sbox_sweep_checker.sv
// Bench for sbox_sweep_checker: two instances (LAT=0 and LAT=2) driven by a shared lookup-table stub.
module tb_sbox_sweep_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  start_v;
    logic [1:0]  busy, done, bij, dup;
    logic [5:0]  sx [2];
    logic [5:0]  sy [2];
    logic [5:0]  fdx [2];
    logic [5:0]  rdd [2];
    logic [6:0]  fcnt [2];
    logic [11:0] ysum [2];
    logic [5:0]  rd_addr;
    logic [5:0]  lut [64];

    int errors = 0;
    int checks = 0;

    assign sy[0] = lut[sx[0]];
    assign sy[1] = lut[sx[1]];

    sbox_sweep_checker #(.N(6), .LAT(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy[0]), .done(done[0]),
        .sbox_x(sx[0]), .sbox_y(sy[0]), .bijective(bij[0]), .dup_found(dup[0]),
        .first_dup_x(fdx[0]), .fixed_cnt(fcnt[0]), .y_sum(ysum[0]),
        .rd_addr(rd_addr), .rd_data(rdd[0])
    );

    sbox_sweep_checker #(.N(6), .LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy[1]), .done(done[1]),
        .sbox_x(sx[1]), .sbox_y(sy[1]), .bijective(bij[1]), .dup_found(dup[1]),
        .first_dup_x(fdx[1]), .fixed_cnt(fcnt[1]), .y_sum(ysum[1]),
        .rd_addr(rd_addr), .rd_data(rdd[1])
    );

    function automatic int lat_of(input int w);
        return (w == 0) ? 0 : 2;
    endfunction

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // GF(2^6) with modulus x^6 + x + 1
    function automatic logic [5:0] gmul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] r, aa;
        r  = '0;
        aa = a;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) r = r ^ aa;
            aa = aa[5] ? ((aa << 1) ^ 6'h03) : (aa << 1);
        end
        return r;
    endfunction

    function automatic logic [5:0] pow34(input logic [5:0] x);
        logic [5:0] s;
        s = x;
        for (int i = 0; i < 5; i++) s = gmul(s, s);
        return gmul(s, gmul(x, x));
    endfunction

    task automatic load_identity();
        for (int i = 0; i < 64; i++) lut[i] = 6'(i);
    endtask

    task automatic load_const(input int c);
        for (int i = 0; i < 64; i++) lut[i] = 6'(c);
    endtask

    task automatic load_perm();
        logic [5:0] t;
        int j;
        load_identity();
        for (int i = 63; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = lut[i]; lut[i] = lut[j]; lut[j] = t;
        end
    endtask

    task automatic load_rand();
        for (int i = 0; i < 64; i++) lut[i] = 6'($urandom_range(63, 0));
    endtask

    task automatic check_zero(input int w, input string tag);
        chk({tag, " busy"}, busy[w], 0);
        chk({tag, " done"}, done[w], 0);
        chk({tag, " sbox_x"}, sx[w], 0);
        chk({tag, " bij"}, bij[w], 0);
        chk({tag, " dup"}, dup[w], 0);
        chk({tag, " fdx"}, fdx[w], 0);
        chk({tag, " fcnt"}, fcnt[w], 0);
        chk({tag, " ysum"}, ysum[w], 0);
    endtask

    // Reference: walk the table in x order applying the result rules directly.
    task automatic check_results(input int w, input string tag, input int nrd);
        bit seen [64];
        int e_dup, e_fdx, e_fix, e_sum, a;
        e_dup = 0; e_fdx = 0; e_fix = 0; e_sum = 0;
        for (int i = 0; i < 64; i++) seen[i] = 1'b0;
        for (int x = 0; x < 64; x++) begin
            if (seen[lut[x]] && e_dup == 0) begin
                e_dup = 1;
                e_fdx = x;
            end
            seen[lut[x]] = 1'b1;
            if (int'(lut[x]) == x) e_fix++;
            e_sum += int'(lut[x]);
        end
        e_sum = e_sum % 4096;
        chk({tag, " bij"}, bij[w], 1 - e_dup);
        chk({tag, " dup"}, dup[w], e_dup);
        chk({tag, " fdx"}, fdx[w], e_fdx);
        chk({tag, " fcnt"}, fcnt[w], e_fix);
        chk({tag, " ysum"}, ysum[w], e_sum);
        for (int k = 0; k < nrd; k++) begin
            a = $urandom_range(63, 0);
            rd_addr = 6'(a);
            #1;
            chk({tag, " rd"}, rdd[w], int'(lut[a]));
        end
    endtask

    // Starts a sweep on instance w; returns at the negedge after the done cycle.
    task automatic run(input int w, input int inj_s, input int inj_r,
                       output int dcyc, output int bcyc, output int dn);
        int lim;
        lim  = 64 * (lat_of(w) + 1) + 8;
        dcyc = -1; bcyc = 0; dn = 0;
        start_v[w] = 1'b1;
        @(posedge clk);
        for (int n = 0; n < lim; n++) begin
            @(negedge clk);
            if (inj_r >= 0 && n == inj_r + 1) check_zero(w, "mid_rst");
            if (busy[w]) bcyc++;
            if (done[w]) begin
                dn++;
                if (dcyc < 0) dcyc = n;
            end
            start_v[w] = (n == inj_s);
            rst        = (n == inj_r);
            if (dcyc >= 0 && n == dcyc + 1) break;
        end
        start_v[w] = 1'b0;
        rst        = 1'b0;
    endtask

    int d, b, dn, w;

    initial begin
        rst = 1'b1; start_v = '0; rd_addr = '0;
        load_identity();
        repeat (3) @(negedge clk);
        check_zero(0, "rst0");
        check_zero(1, "rst2");
        rst = 1'b0;

        @(negedge clk);
        run(0, -1, -1, d, b, dn);
        chk("id done_cyc", d, 64);
        chk("id busy_cyc", b, 64);
        chk("id pulses", dn, 1);
        chk("id fcnt64", fcnt[0], 64);
        chk("id sum7e0", ysum[0], 12'h7E0);
        rd_addr = 6'd37; #1;
        chk("id rd37", rdd[0], 37);
        check_results(0, "id", 3);

        for (int i = 0; i < 64; i++) lut[i] = pow34(6'(i));
        @(negedge clk);
        run(1, -1, -1, d, b, dn);
        chk("p34 done_cyc", d, 192);
        chk("p34 busy_cyc", b, 192);
        chk("p34 bij", bij[1], 1);
        chk("p34 sum7e0", ysum[1], 12'h7E0);
        chk("p34 fcnt4", fcnt[1], 4);
        check_results(1, "p34", 3);

        load_const(5);
        @(negedge clk);
        run(0, -1, -1, d, b, dn);
        chk("c5 fdx1", fdx[0], 1);
        chk("c5 sum320", ysum[0], 320);
        check_results(0, "c5", 2);

        load_identity();
        @(negedge clk);
        run(0, -1, 20, d, b, dn);
        chk("rst no_done", dn, 0);
        @(negedge clk);
        run(0, -1, -1, d, b, dn);
        chk("post_rst done_cyc", d, 64);
        check_results(0, "post_rst", 2);

        @(negedge clk);
        run(0, 10, -1, d, b, dn);
        chk("restart done_cyc", d, 64);
        chk("restart pulses", dn, 1);
        check_results(0, "restart", 1);

        load_const(5);
        @(negedge clk);
        run(0, -1, -1, d, b, dn);
        check_results(0, "b2b1", 0);
        load_identity();
        run(0, -1, -1, d, b, dn);
        chk("b2b2 done_cyc", d, 64);
        chk("b2b2 dup0", dup[0], 0);
        check_results(0, "b2b2", 2);

        for (int it = 0; it < 6; it++) begin
            w = it % 2;
            if (it < 3) load_perm(); else load_rand();
            @(negedge clk);
            run(w, -1, -1, d, b, dn);
            chk("rnd done_cyc", d, 64 * (lat_of(w) + 1));
            chk("rnd pulses", dn, 1);
            check_results(w, "rnd", 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
